// File: rtl/video_capture.sv
// video_capture: measures incoming DVI active size, locks on a stable format and streams captured frames as RGB565 pixel writes
// Ports: pixel_clk/sys_rst clock and sync reset; video_hs/vs/de/rgb decoded video in;
//   capture_en frame capture request; wr_full writer backpressure;
//   wr_en/wr_data/wr_xpos/wr_ypos pixel write stream; frame_start/frame_done frame pulses;
//   h_disp/v_disp measured size; locked format stable; drop_err sticky dropped-pixel flag
module video_capture #(
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  input  logic        capture_en,
  input  logic        wr_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic [10:0] wr_xpos,
  output logic [10:0] wr_ypos,
  output logic        frame_start,
  output logic        frame_done,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        locked,
  output logic        drop_err
);
  typedef enum logic [1:0] {IDLE, MEASURE, CAPTURE} state_t;
  state_t r_state;
  logic r_hs, r_vs, r_vs_d, r_de, r_de_d, r_cap;
  logic [15:0] r_rgb;
  logic [10:0] r_x, r_line, r_hmax;
  logic [7:0] r_match;
  logic w_vs_edge, w_de_fall, w_zero, w_same, w_go, w_unused;
  logic [10:0] w_h, w_v;
  logic [7:0] w_match;
  assign w_vs_edge = r_vs & ~r_vs_d;
  assign w_de_fall = r_de_d & ~r_de;
  // a line still open at the frame boundary counts as ended
  assign w_h = (r_x > r_hmax) ? r_x : r_hmax;
  assign w_v = (r_x != 11'd0 && r_line != 11'h7ff) ? r_line + 11'd1 : r_line;
  assign w_zero = (w_h == 11'd0) || (w_v == 11'd0);
  assign w_same = !w_zero && w_h == h_disp && w_v == v_disp;
  assign w_match = w_zero ? 8'd0 : !w_same ? 8'd1 : (r_match == 8'(LOCK_FRAMES)) ? r_match : r_match + 8'd1;
  assign w_go = (r_state == CAPTURE) ? w_same : (r_state == MEASURE && w_match == 8'(LOCK_FRAMES));
  assign w_unused = &{1'b0, r_hs, video_rgb[18:16], video_rgb[9:8], video_rgb[2:0]};
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_vs_d <= 1'b0;
      r_de <= 1'b0;
      r_de_d <= 1'b0;
      r_rgb <= '0;
      r_x <= '0;
      r_line <= '0;
      r_hmax <= '0;
      r_match <= '0;
      r_cap <= 1'b0;
      r_state <= IDLE;
      wr_en <= 1'b0;
      wr_data <= '0;
      wr_xpos <= '0;
      wr_ypos <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      h_disp <= '0;
      v_disp <= '0;
      locked <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      r_hs <= video_hs ~^ HS_POL;
      r_vs <= video_vs ~^ VS_POL;
      r_vs_d <= r_vs;
      r_de <= video_de;
      r_de_d <= r_de;
      r_rgb <= {video_rgb[23:19], video_rgb[15:10], video_rgb[7:3]};
      r_x <= (w_vs_edge || w_de_fall) ? 11'd0 : (r_de && r_x != 11'h7ff) ? r_x + 11'd1 : r_x;
      r_line <= w_vs_edge ? 11'd0 : (w_de_fall && r_line != 11'h7ff) ? r_line + 11'd1 : r_line;
      r_hmax <= w_vs_edge ? 11'd0 : (w_de_fall && r_x > r_hmax) ? r_x : r_hmax;
      wr_en <= r_de && r_cap && !wr_full;
      wr_data <= r_rgb;
      wr_xpos <= r_x;
      wr_ypos <= r_line;
      drop_err <= drop_err | (r_de & r_cap & wr_full);
      frame_start <= w_vs_edge && w_go && capture_en;
      frame_done <= w_vs_edge && r_cap;
      if (w_vs_edge) begin
        r_state <= w_go ? CAPTURE : MEASURE;
        locked <= w_go;
        r_cap <= w_go && capture_en;
        if (r_state != IDLE) begin
          h_disp <= w_h;
          v_disp <= w_v;
          r_match <= w_match;
        end
      end
    end
  end
endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed frame-level checks of video_capture with both sync polarities side by side
module tb_video_capture;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, hs, vs, de, cen, full;
  logic hs_n, vs_n;
  logic [23:0] rgb;
  assign hs_n = ~hs;
  assign vs_n = ~vs;
  logic wr_en [2], frame_start [2], frame_done [2], locked [2], drop_err [2];
  logic [15:0] wr_data [2];
  logic [10:0] wr_xpos [2], wr_ypos [2], h_disp [2], v_disp [2];
  video_capture #(.HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) dut_p (
    .pixel_clk(clk), .sys_rst(rst), .video_hs(hs), .video_vs(vs), .video_de(de),
    .video_rgb(rgb), .capture_en(cen), .wr_full(full), .wr_en(wr_en[0]),
    .wr_data(wr_data[0]), .wr_xpos(wr_xpos[0]), .wr_ypos(wr_ypos[0]),
    .frame_start(frame_start[0]), .frame_done(frame_done[0]), .h_disp(h_disp[0]),
    .v_disp(v_disp[0]), .locked(locked[0]), .drop_err(drop_err[0]));
  video_capture #(.HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)) dut_n (
    .pixel_clk(clk), .sys_rst(rst), .video_hs(hs_n), .video_vs(vs_n), .video_de(de),
    .video_rgb(rgb), .capture_en(cen), .wr_full(full), .wr_en(wr_en[1]),
    .wr_data(wr_data[1]), .wr_xpos(wr_xpos[1]), .wr_ypos(wr_ypos[1]),
    .frame_start(frame_start[1]), .frame_done(frame_done[1]), .h_disp(h_disp[1]),
    .v_disp(v_disp[1]), .locked(locked[1]), .drop_err(drop_err[1]));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_wr [2] = '{0, 0};
  int n_fs [2] = '{0, 0};
  int n_fd [2] = '{0, 0};
  int fs_cyc [2] = '{0, 0};
  int lock_cyc [2] = '{0, 0};
  int first_wr_cyc [2] = '{0, 0};
  logic fresh [2] = '{1'b0, 1'b0};
  logic lock_d [2] = '{1'b0, 1'b0};
  logic [10:0] first_x [2], first_y [2], last_x [2], last_y [2];
  logic [15:0] last_d [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (frame_start[i]) begin
        n_fs[i]++;
        fs_cyc[i] = cyc;
        fresh[i] = 1'b1;
      end
      if (frame_done[i]) n_fd[i]++;
      if (locked[i] && !lock_d[i]) lock_cyc[i] = cyc;
      lock_d[i] = locked[i];
      if (wr_en[i]) begin
        n_wr[i]++;
        if (fresh[i]) begin
          first_x[i] = wr_xpos[i];
          first_y[i] = wr_ypos[i];
          first_wr_cyc[i] = cyc;
          fresh[i] = 1'b0;
        end
        last_x[i] = wr_xpos[i];
        last_y[i] = wr_ypos[i];
        last_d[i] = wr_data[i];
      end
    end
  end
  int n_cmp = 0;
  int n_bad = 0;
  int fno = 0;
  int vs_cyc = 0;
  int de_cyc = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic h, input logic v, input logic d);
    @(negedge clk);
    hs = h;
    vs = v;
    de = d;
  endtask
  task automatic frame(input int w, input int h, input logic en_mid, input int full_line, input int rst_line);
    tick(1'b0, 1'b1, 1'b0);
    vs_cyc = cyc;
    tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < h; l++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      for (int p = 0; p < w; p++) begin
        tick(1'b0, 1'b0, 1'b1);
        if (l == 0 && p == 0) de_cyc = cyc;
        full = (l == full_line && p >= 2 && p <= 4);
        if (l == 1 && p == 3) cen = en_mid;
        if (l == rst_line && p == 4) rst = 1'b1;
        if (l == rst_line && p == 5) begin
          rst = 1'b0;
          for (int i = 0; i < 2; i++) begin
            check($sformatf("mid_rst_wr_en%0d", i), wr_en[i], 0);
            check($sformatf("mid_rst_locked%0d", i), locked[i], 0);
            check($sformatf("mid_rst_h_disp%0d", i), h_disp[i], 0);
            check($sformatf("mid_rst_v_disp%0d", i), v_disp[i], 0);
            check($sformatf("mid_rst_drop_err%0d", i), drop_err[i], 0);
            check($sformatf("mid_rst_wr_xpos%0d", i), wr_xpos[i], 0);
          end
        end
      end
      tick(1'b0, 1'b0, 1'b0);
      full = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask
  task automatic run(input int w, input int h, input logic en_mid, input int full_line, input int rst_line,
                     input int exp_wr, input int exp_fs, input int exp_fd, input logic exp_lock);
    int s_wr [2];
    int s_fs [2];
    int s_fd [2];
    for (int i = 0; i < 2; i++) begin
      s_wr[i] = n_wr[i];
      s_fs[i] = n_fs[i];
      s_fd[i] = n_fd[i];
    end
    frame(w, h, en_mid, full_line, rst_line);
    fno++;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("f%0d_wr_count%0d", fno, i), n_wr[i] - s_wr[i], exp_wr);
      check($sformatf("f%0d_frame_start%0d", fno, i), n_fs[i] - s_fs[i], exp_fs);
      check($sformatf("f%0d_frame_done%0d", fno, i), n_fd[i] - s_fd[i], exp_fd);
      check($sformatf("f%0d_locked%0d", fno, i), locked[i], exp_lock);
    end
  endtask
  initial begin
    rst = 1'b1;
    hs = 1'b0;
    vs = 1'b0;
    de = 1'b0;
    cen = 1'b1;
    full = 1'b0;
    rgb = 24'h123456;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_wr_en%0d", i), wr_en[i], 0);
      check($sformatf("rst_locked%0d", i), locked[i], 0);
      check($sformatf("rst_h_disp%0d", i), h_disp[i], 0);
      check($sformatf("rst_frame_start%0d", i), frame_start[i], 0);
      check($sformatf("rst_drop_err%0d", i), drop_err[i], 0);
    end
    rst = 1'b0;
    run(8, 4, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run(8, 4, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("meas_h_disp%0d", i), h_disp[i], 8);
      check($sformatf("meas_v_disp%0d", i), v_disp[i], 4);
    end
    run(8, 4, 1'b1, -1, -1, 32, 1, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("lock_latency%0d", i), lock_cyc[i] - vs_cyc, 2);
      check($sformatf("start_latency%0d", i), fs_cyc[i] - vs_cyc, 2);
      check($sformatf("pixel_latency%0d", i), first_wr_cyc[i] - de_cyc, 2);
      check($sformatf("first_xy%0d", i), {first_x[i], first_y[i]}, {11'd0, 11'd0});
      check($sformatf("last_xy%0d", i), {last_x[i], last_y[i]}, {11'd7, 11'd3});
      check($sformatf("data_123456_%0d", i), last_d[i], 16'h11AA);
    end
    rgb = 24'hFF8040;
    run(8, 4, 1'b1, -1, -1, 32, 1, 1, 1'b1);
    for (int i = 0; i < 2; i++) check($sformatf("data_ff8040_%0d", i), last_d[i], 16'hFC08);
    run(8, 4, 1'b0, -1, -1, 32, 1, 1, 1'b1);
    run(8, 4, 1'b1, -1, -1, 0, 0, 1, 1'b1);
    run(8, 4, 1'b1, -1, -1, 32, 1, 0, 1'b1);
    run(8, 4, 1'b1, 1, -1, 29, 1, 1, 1'b1);
    for (int i = 0; i < 2; i++) check($sformatf("drop_err_set%0d", i), drop_err[i], 1);
    run(8, 4, 1'b1, -1, -1, 32, 1, 1, 1'b1);
    for (int i = 0; i < 2; i++) check($sformatf("drop_err_sticky%0d", i), drop_err[i], 1);
    run(10, 4, 1'b1, -1, -1, 40, 1, 1, 1'b1);
    for (int i = 0; i < 2; i++) check($sformatf("wide_last_xy%0d", i), {last_x[i], last_y[i]}, {11'd9, 11'd3});
    run(10, 4, 1'b1, -1, -1, 0, 0, 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("resize_h_disp%0d", i), h_disp[i], 10);
      check($sformatf("resize_v_disp%0d", i), v_disp[i], 4);
    end
    run(10, 4, 1'b1, -1, -1, 40, 1, 0, 1'b1);
    run(10, 4, 1'b1, -1, 1, 13, 1, 1, 1'b0);
    run(10, 4, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run(10, 4, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) check($sformatf("relock_h_disp%0d", i), h_disp[i], 10);
    run(10, 4, 1'b1, -1, -1, 40, 1, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
